mem_uncached_wbuf: RTL and testbench
====================================

// Module: mem_uncached_wbuf
// PURPOSE
//   Uncached load/store engine for the MEM stage with a posted store (write) buffer.
//   Stores to the uncached window retire without waiting for the bus; loads drain the buffer first, then issue.
//   Sits between the MEM stage and the SRAM-like data port; replaces the single-shot uncached path.
// PARAMETERS
//   WBUF_DEPTH  4              store-buffer entries (power of two, >=2)
//   UC_BASE     32'hA000_0000  lowest uncached address (inclusive)
//   UC_LIMIT    32'hBFFF_FFFF  highest uncached address (inclusive)
// PORTS
//   clk         in   1   clock
//   aresetn     in   1   asynchronous reset, active low
//   req_valid   in   1   MEM-stage access this cycle; held while stall=1, low when not advancing
//   req_wr      in   1   1=store, 0=load
//   req_type    in   3   [1:0] 00 byte/01 half/10 word; [2] 1=zero-extend load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data, right-justified
//   req_kill    in   1   exception on this instruction: suppress access
//   uc_hit      out  1   req_addr in [UC_BASE,UC_LIMIT] (combinational)
//   rdata       out  32  extended load data
//   stall       out  1   hold MEM stage
//   wbuf_empty  out  1   no pending stores
//   adel / ades out  1   misaligned load/store (macro only; tied 0 otherwise)
//   mem_req     out  1   | SRAM-like port: request, write, size (0/1/2 = 1/2/4 bytes),
//   mem_wr      out  1   | byte address, write data (lane-replicated)
//   mem_size    out  2   |
//   mem_addr    out  32  |
//   mem_wdata   out  32  |
//   mem_rdata   in   32  |
//   mem_addr_ok in   1   | request accepted
//   mem_data_ok in   1   | write done / read data valid
// BEHAVIOUR
//   Accepted access = req_valid & uc_hit & !req_kill (& aligned with macro).
//   Reset: FSM IDLE, buffer empty, mem_req=0, rdata=0, stall=0, wbuf_empty=1, adel=ades=0.
//   Store: enqueued {addr,size,lane-replicated data} on the edge where it is accepted and
//     buffer not full; stall=0. Full: stall=1 until a pop frees a slot. Enqueue+pop same edge:
//     count unchanged.
//   Load: stall=1 until buffer empty and read returns. Read issued only when empty (strict
//     program order). In cycle mem_data_ok (R_DATA): stall=0, rdata = extended mem_rdata
//     lane; rdata registered and held until next load completes.
//   FSM (one transaction outstanding): IDLE -> W_ADDR (buffer nonempty, head)
//     | R_ADDR (load pending, empty); W_ADDR/R_ADDR: mem_req=1, fields stable until addr_ok
//     -> W_DATA/R_DATA; W_DATA: data_ok pops head -> IDLE; R_DATA: data_ok -> IDLE.
//     addr_ok and data_ok in same cycle: complete directly to IDLE.
//   Drain priority over loads; stores keep enqueuing during drain.
//   Extension: byte/half lane from addr[1:0]; sign unless req_type[2].
//   req_kill while stalled on a load in R_ADDR before addr_ok: request dropped, stall=0;
//     after addr_ok: transaction completes, result discarded.
//   Pointers wrap modulo WBUF_DEPTH; count is $clog2(WBUF_DEPTH)+1 bits.
//   Reset mid-transaction: state/buffer cleared at once; pending bus response ignored.
// CONFIGURATION
//   UNCACHED_ALIGN_CHK_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 raises
//     adel (load) / ades (store) combinationally, access suppressed, stall=0.
//   Undefined: no check, adel=ades=0, addr low bits forced to size alignment on the bus.
// STRUCTURE
//   mem_pkg: access-size enum, uc_state_t FSM enum, wbuf_entry_t {addr,size,data} struct,
//     UC_BASE/UC_LIMIT defaults.
//   Sub-module wbuf_fifo: WBUF_DEPTH x wbuf_entry_t FIFO (push/pop/full/empty/head).
// TESTING
//   sb 0xA0000003 data 0x5A, addr_ok/data_ok in 1 cycle -> stall=0, one write size 0,
//     addr 0xA0000003, wdata 0x5A5A5A5A.
//   5 back-to-back sw, DEPTH=4, slave addr_ok 3-cycle delay -> stall on 5th until first pop;
//     5 writes in order.
//   sw 0xBFD0_0000 then lb same addr, rdata 0x000000F0 -> read issued after write data_ok;
//     rdata=0xFFFFFFF0; lbu -> 0x000000F0.
//   addr_ok and data_ok same cycle on read -> load completes that cycle, FSM IDLE next.
//   aresetn low mid W_DATA with 2 entries -> wbuf_empty=1, mem_req=0 immediately.
//   With macro: lw 0xA0000002 -> adel=1, mem_req never asserted; without: addr 0xA0000000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the uncached MEM-stage access path.
// Covers access sizes, FSM states, store-buffer entries and the lane/extension helpers.
package mem_pkg;

  localparam logic [31:0] UC_BASE_DEF  = 32'hA000_0000;
  localparam logic [31:0] UC_LIMIT_DEF = 32'hBFFF_FFFF;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    UC_IDLE,
    UC_W_ADDR,
    UC_W_DATA,
    UC_R_ADDR,
    UC_R_DATA
  } uc_state_t;

  typedef struct packed {
    logic [31:0] addr;
    mem_size_e   size;
    logic [31:0] data;
  } wbuf_entry_t;

  // The reserved encoding 2'b11 is treated as a word access.
  function automatic mem_size_e to_size(input logic [1:0] t);
    case (t)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] a, input mem_size_e sz);
    case (sz)
      SZ_BYTE: return a;
      SZ_HALF: return {a[31:1], 1'b0};
      default: return {a[31:2], 2'b00};
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [31:0] d, input mem_size_e sz);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Half lanes are picked by addr[1] only, matching the size-aligned bus address.
  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] off,
                                              input mem_size_e sz, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {off, 3'b000});
    h = 16'(d >> {off[1], 4'b0000});
    case (sz)
      SZ_BYTE: return zext ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return zext ? {16'b0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store FIFO of wbuf_entry_t; head is visible combinationally, no added latency.
// Caller must not push when full unless popping on the same edge; pop on empty is ignored by design contract.
module wbuf_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        push,
  input  wbuf_entry_t push_dat,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output wbuf_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  wbuf_entry_t       store [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = store[rd_ptr];

endmodule

// File: rtl/mem_uncached_wbuf.sv
// Uncached load/store engine with posted store buffer; stores retire at once, loads drain the buffer then read.
// Stalls on a full buffer or an outstanding load; UNCACHED_ALIGN_CHK_EN adds adel/ades misalignment traps.
module mem_uncached_wbuf
  import mem_pkg::*;
#(
  parameter int          WBUF_DEPTH = 4,
  parameter logic [31:0] UC_BASE    = UC_BASE_DEF,
  parameter logic [31:0] UC_LIMIT   = UC_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_kill,
  output logic        uc_hit,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        wbuf_empty,
  output logic        adel,
  output logic        ades,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  uc_state_t   state, state_nxt;
  mem_size_e   req_size;
  logic        base_ok, acc, acc_st, acc_ld;
  logic        push, pop, fifo_full, fifo_empty;
  logic        rd_done, rd_live;
  logic [31:0] rdata_q, ld_ext;
  wbuf_entry_t head, new_entry;

  assign uc_hit   = (req_addr >= UC_BASE) && (req_addr <= UC_LIMIT);
  assign req_size = to_size(req_type[1:0]);
  assign base_ok  = req_valid && uc_hit && !req_kill;

`ifdef UNCACHED_ALIGN_CHK_EN
  logic misal;
  assign misal = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign adel  = base_ok && !req_wr && misal;
  assign ades  = base_ok && req_wr && misal;
  assign acc   = base_ok && !misal;
`else
  assign adel  = 1'b0;
  assign ades  = 1'b0;
  assign acc   = base_ok;
`endif

  assign acc_st = acc && req_wr;
  assign acc_ld = acc && !req_wr;

  assign new_entry.addr = align_addr(req_addr, req_size);
  assign new_entry.size = req_size;
  assign new_entry.data = lane_replicate(req_wdata, req_size);

  // A full buffer still accepts when the head retires on the same edge.
  assign push = acc_st && (!fifo_full || pop);

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_fifo (
    .clk      (clk),
    .aresetn  (aresetn),
    .push     (push),
    .push_dat (new_entry),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= UC_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = req_size;
    mem_addr  = align_addr(req_addr, req_size);
    mem_wdata = '0;
    pop       = 1'b0;
    rd_done   = 1'b0;
    case (state)
      UC_IDLE: begin
        if (!fifo_empty)  state_nxt = UC_W_ADDR;
        else if (acc_ld)  state_nxt = UC_R_ADDR;
      end
      UC_W_ADDR, UC_W_DATA: begin
        mem_req   = (state == UC_W_ADDR);
        mem_wr    = 1'b1;
        mem_size  = head.size;
        mem_addr  = head.addr;
        mem_wdata = head.data;
        if (state == UC_W_DATA) begin
          if (mem_data_ok) begin
            pop       = 1'b1;
            state_nxt = UC_IDLE;
          end
        end else if (mem_addr_ok) begin
          pop       = mem_data_ok;
          state_nxt = mem_data_ok ? UC_IDLE : UC_W_DATA;
        end
      end
      UC_R_ADDR: begin
        // A load killed before acceptance withdraws its request.
        mem_req = acc_ld;
        if (!acc_ld) state_nxt = UC_IDLE;
        else if (mem_addr_ok) begin
          rd_done   = mem_data_ok;
          state_nxt = mem_data_ok ? UC_IDLE : UC_R_DATA;
        end
      end
      UC_R_DATA: begin
        if (mem_data_ok) begin
          rd_done   = rd_live && acc_ld;
          state_nxt = UC_IDLE;
        end
      end
      default: state_nxt = UC_IDLE;
    endcase
  end

  // Cleared once the requesting load leaves the stage, so a late response is discarded.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rd_live <= 1'b0;
    else if (state == UC_R_ADDR && acc_ld && mem_addr_ok && !mem_data_ok) rd_live <= 1'b1;
    else if (state == UC_R_DATA && !acc_ld) rd_live <= 1'b0;
  end

  assign ld_ext = load_extend(mem_rdata, req_addr[1:0], req_size, req_type[2]);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)     rdata_q <= '0;
    else if (rd_done) rdata_q <= ld_ext;
  end

  assign rdata      = rd_done ? ld_ext : rdata_q;
  assign stall      = (acc_st && fifo_full && !pop) || (acc_ld && !rd_done);
  assign wbuf_empty = fifo_empty;

endmodule

// File: tb/tb_mem_uncached_wbuf.sv
// Directed bench for mem_uncached_wbuf: SRAM-like slave model with a request scoreboard and a load-result monitor.
module tb_mem_uncached_wbuf;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, req_kill = 1'b0;
  logic [2:0]  req_type = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        uc_hit, stall, wbuf_empty, adel, ades;
  logic [31:0] rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_ld[$];
  int          checks = 0;
  int          errors = 0;

  int          ad_dly = 0, dd_dly = 0;
  bit          same_cyc = 1'b0;
  int          acnt = 0, dcnt = 0;
  bit          pend = 1'b0;
  logic [31:0] rd_val = '0;
  int          exp_st[5] = '{0, 0, 0, 0, 2};

  mem_uncached_wbuf dut (
    .clk(clk), .aresetn(aresetn),
    .req_valid(req_valid), .req_wr(req_wr), .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_kill(req_kill),
    .uc_hit(uc_hit), .rdata(rdata), .stall(stall), .wbuf_empty(wbuf_empty),
    .adel(adel), .ades(ades),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic exp_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.wr = wr; e.size = sz; e.addr = a; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  task automatic check_bus();
    bus_t e;
    checks++;
    if (exp_bus.size() == 0) begin
      errors++;
      $display("FAIL bus_unexpected wr=%0b size=%0d addr=%h", mem_wr, mem_size, mem_addr);
    end else begin
      e = exp_bus.pop_front();
      if (mem_wr !== e.wr || mem_size !== e.size || mem_addr !== e.addr ||
          (e.wr && mem_wdata !== e.wdata)) begin
        errors++;
        $display("FAIL bus_req got wr=%0b sz=%0d a=%h d=%h exp wr=%0b sz=%0d a=%h d=%h",
                 mem_wr, mem_size, mem_addr, mem_wdata, e.wr, e.size, e.addr, e.wdata);
      end
    end
  endtask

  // SRAM-like slave: programmable addr_ok / data_ok delays; keeps a pending response across reset.
  always @(negedge clk) begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (pend) begin
      if (dcnt >= dd_dly) begin
        mem_data_ok = 1'b1; mem_rdata = rd_val; pend = 1'b0; dcnt = 0;
      end else dcnt++;
    end else if (mem_req) begin
      if (acnt >= ad_dly) begin
        mem_addr_ok = 1'b1; acnt = 0;
        check_bus();
        if (same_cyc) begin
          mem_data_ok = 1'b1; mem_rdata = rd_val;
        end else begin
          pend = 1'b1; dcnt = 0;
        end
      end else acnt++;
    end else acnt = 0;
  end

  // Load completion monitor: a non-stalled accepted load presents its result this cycle.
  always @(negedge clk) begin
    #2;
    if (aresetn && req_valid && !req_wr && !req_kill && uc_hit && !stall && !adel) begin
      if (exp_ld.size() == 0) begin
        checks++; errors++;
        $display("FAIL load_unexpected rdata=%h", rdata);
      end else chk("load_rdata", rdata, exp_ld.pop_front());
    end
  end

  // Starts and ends at posedge+1; returns the number of stalled cycles.
  task automatic issue(input logic wr, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, output int sc);
    req_valid = 1'b1; req_wr = wr; req_type = t; req_addr = a; req_wdata = d;
    sc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (!stall) break;
      sc++;
    end
    if (sc >= 200) begin
      checks++; errors++;
      $display("FAIL issue_timeout addr=%h", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic release_req();
    req_valid = 1'b0; req_kill = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(wbuf_empty && !pend && exp_bus.size() == 0) && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d", exp_bus.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int sc;
    #1 aresetn = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_wbuf_empty", wbuf_empty, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_adel", adel, 0);
    chk("rst_ades", ades, 0);
    @(posedge clk); #1 aresetn = 1'b1;

    req_addr = 32'h9FFF_FFFF; #1 chk("uc_below", uc_hit, 0);
    req_addr = 32'hA000_0000; #1 chk("uc_base", uc_hit, 1);
    req_addr = 32'hBFFF_FFFF; #1 chk("uc_limit", uc_hit, 1);
    req_addr = 32'hC000_0000; #1 chk("uc_above", uc_hit, 0);
    @(posedge clk); #1;

    // Single byte store, immediate handshakes.
    exp_req(1, 2'd0, 32'hA000_0003, 32'h5A5A_5A5A);
    issue(1, 3'b000, 32'hA000_0003, 32'h0000_005A, sc);
    chk("sb_stall", sc, 0);
    release_req();
    wait_drain();
    chk("sb_empty", wbuf_empty, 1);

    // Five back-to-back words into a 4-deep buffer with a slow address phase.
    ad_dly = 3;
    for (int i = 0; i < 5; i++) exp_req(1, 2'd2, 32'hA000_0100 + 4 * i, 32'h1111_0001 + i);
    for (int i = 0; i < 5; i++) begin
      issue(1, 3'b010, 32'hA000_0100 + 4 * i, 32'h1111_0001 + i, sc);
      chk("sw_burst_stall", sc, exp_st[i]);
    end
    release_req();
    wait_drain();
    ad_dly = 0;

    // Store then loads to the same address: reads only after the buffer drains.
    dd_dly = 1;
    exp_req(1, 2'd2, 32'hBFD0_0000, 32'h0000_00F0);
    issue(1, 3'b010, 32'hBFD0_0000, 32'h0000_00F0, sc);
    rd_val = 32'h0000_00F0;
    exp_req(0, 2'd0, 32'hBFD0_0000, 32'h0); exp_ld.push_back(32'hFFFF_FFF0);
    issue(0, 3'b000, 32'hBFD0_0000, 32'h0, sc);
    exp_req(0, 2'd0, 32'hBFD0_0000, 32'h0); exp_ld.push_back(32'h0000_00F0);
    issue(0, 3'b100, 32'hBFD0_0000, 32'h0, sc);
    rd_val = 32'h8001_0000;
    exp_req(0, 2'd1, 32'hBFD0_0002, 32'h0); exp_ld.push_back(32'hFFFF_8001);
    issue(0, 3'b001, 32'hBFD0_0002, 32'h0, sc);
    exp_req(0, 2'd1, 32'hBFD0_0002, 32'h0); exp_ld.push_back(32'h0000_8001);
    issue(0, 3'b101, 32'hBFD0_0002, 32'h0, sc);
    release_req();
    repeat (3) @(posedge clk);
    #1 chk("rdata_hold", rdata, 32'h0000_8001);
    dd_dly = 0;

    // addr_ok and data_ok together: completes in-cycle, FSM free for the next load.
    same_cyc = 1'b1;
    rd_val = 32'hCAFE_BABE;
    exp_req(0, 2'd2, 32'hA000_0010, 32'h0); exp_ld.push_back(32'hCAFE_BABE);
    issue(0, 3'b010, 32'hA000_0010, 32'h0, sc);
    chk("rd_same_cyc_stall", sc, 1);
    rd_val = 32'h0BAD_F00D;
    exp_req(0, 2'd2, 32'hA000_0014, 32'h0); exp_ld.push_back(32'h0BAD_F00D);
    issue(0, 3'b010, 32'hA000_0014, 32'h0, sc);
    chk("rd_back2back_stall", sc, 1);
    release_req();
    same_cyc = 1'b0;

    // Load killed while waiting for addr_ok: request withdrawn, stall released.
    ad_dly = 5;
    req_valid = 1'b1; req_wr = 1'b0; req_type = 3'b010; req_addr = 32'hA000_0020;
    @(negedge clk); #2 chk("kill_pre_stall", stall, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 req_kill = 1'b1;
    #1 chk("kill_stall", stall, 0);
    chk("kill_mem_req", mem_req, 0);
    @(posedge clk); #1 release_req();
    repeat (8) @(posedge clk);
    #1 ad_dly = 0;

    // Reset while a write sits in W_DATA with a second entry queued.
    dd_dly = 20;
    exp_req(1, 2'd2, 32'hA000_0200, 32'h1111_1111);
    issue(1, 3'b010, 32'hA000_0200, 32'h1111_1111, sc);
    issue(1, 3'b010, 32'hA000_0204, 32'h2222_2222, sc);
    release_req();
    @(posedge clk); #1 chk("pre_rst_nonempty", wbuf_empty, 0);
    aresetn = 1'b0;
    #1 chk("mid_rst_empty", wbuf_empty, 1);
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_rdata", rdata, 0);
    @(posedge clk); #1 aresetn = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("post_rst_empty", wbuf_empty, 1);
    dd_dly = 0;

`ifdef UNCACHED_ALIGN_CHK_EN
    req_valid = 1'b1; req_wr = 1'b0; req_type = 3'b010; req_addr = 32'hA000_0002;
    #1 chk("misal_adel", adel, 1);
    chk("misal_stall", stall, 0);
    req_wr = 1'b1; req_type = 3'b001; req_addr = 32'hA000_0001;
    #1 chk("misal_ades", ades, 1);
    chk("misal_ades_adel", adel, 0);
    @(posedge clk); #1 release_req();
    repeat (5) @(posedge clk);
    #1 chk("misal_no_req", mem_req, 0);
`else
    rd_val = 32'h1122_3344;
    exp_req(0, 2'd2, 32'hA000_0000, 32'h0); exp_ld.push_back(32'h1122_3344);
    issue(0, 3'b010, 32'hA000_0002, 32'h0, sc);
    exp_req(1, 2'd1, 32'hA000_0000, 32'hBEEF_BEEF);
    issue(1, 3'b001, 32'hA000_0001, 32'h0000_BEEF, sc);
    release_req();
    chk("misal_adel_tied", adel, 0);
`endif
    wait_drain();

    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("load_queue_empty", exp_ld.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
